stream_demux: RTL and testbench
===============================

# stream_demux

Registered 1-to-N stream demultiplexer. It is the distribution counterpart of the mux primitive: one upstream valid/ready stream is steered to one of `N_OUT` downstream valid/ready streams. Each output has a one-entry holding register, so a stalled output never blocks traffic addressed to the other outputs. It sits between a single producer and several independent consumers.

## Interface

**Parameters**
- `N_OUT`, default 4: number of downstream channels; legal range 2..16.
- `WIDTH`, default 8: payload width in bits.
- `SEL_W`: derived, not overridable; equals `$clog2(N_OUT)`.

**Ports**
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `up_valid`, input, 1: upstream word present.
- `up_sel`, input, `SEL_W`: destination channel index.
- `up_data`, input, `WIDTH`: upstream payload.
- `up_ready`, output, 1: upstream word accepted this cycle when high with `up_valid`.
- `dn_valid`, output, `N_OUT`: per-channel word present.
- `dn_data`, output, `N_OUT*WIDTH`: channel i occupies bits `[i*WIDTH +: WIDTH]`.
- `dn_ready`, input, `N_OUT`: per-channel consumer ready.
- `drop_err`, output, 1: one-cycle pulse; a word with an out-of-range `up_sel` was discarded.

## Operation

- **Channel state.** Each channel i has a full flag (`dn_valid[i]`) and a `WIDTH` data register.
- **Target.** `t = up_sel`. The target is out of range when `up_sel >= N_OUT`; this is only possible when `N_OUT` is not a power of 2.
- **Ready.**
  - In range: `up_ready = !dn_valid[t] || dn_ready[t]`. This is combinational from `dn_ready[t]`.
  - Out of range: `up_ready = 1`.
- **Accept** (`up_valid && up_ready`, in range): at the edge, `dn_data[t] <= up_data` and `dn_valid[t] <= 1`.
- **Drain** (`dn_valid[i] && dn_ready[i]`): at the edge, `dn_valid[i] <= 0`, unless channel i accepts a new word on the same edge.
- **Simultaneous drain and accept on one channel:** the new word replaces the old one, `dn_valid` stays 1, and no bubble is inserted.
- **Untargeted channels:** they drain independently in the same cycle.
- **Output stability:** `dn_data[i]` is stable while `dn_valid[i] && !dn_ready[i]`. When `dn_valid[i] = 0`, `dn_data[i]` holds its last value.
- **Out-of-range accept:** the word is discarded and no channel changes. `drop_err <= 1` for exactly one cycle after the edge. Back-to-back drops give a continuous high level.
- **Ordering:** words sent to the same channel leave in acceptance order. There is no ordering guarantee across channels.

## Timing

- **Reset values** (asynchronous, immediate on `rst_n` low): `dn_valid = 0`, all `dn_data = 0`, `drop_err = 0`, round-robin pointer = 0.
- **After reset:**
  - `up_ready = 1` for every `up_sel` value.
  - Words held at reset are lost; no `dn_valid` glitch occurs on release.
- **Latency:** a word accepted at edge k appears on `dn_valid`/`dn_data` immediately after edge k (1 cycle).
- **Throughput:** 1 word per cycle sustained into a channel whose `dn_ready` is held high. Alternating channels also sustain 1 word per cycle.
- **Handshake rules:**
  - `up_valid` must not depend combinationally on `up_ready`.
  - `dn_valid` never depends combinationally on `dn_ready`.

## Configuration

- **Macro:** `STREAM_DEMUX_ROUND_ROBIN_EN`
- **Not defined:** routing follows `up_sel` as described above.
- **Defined:**
  - `up_sel` is ignored and the target is the internal pointer `rr_ptr` (`SEL_W` bits, reset 0).
  - `rr_ptr` advances by 1 on each accepted word and wraps from `N_OUT-1` to 0.
  - While the target channel is full and not draining, `up_ready = 0` and the pointer holds; the stream stalls and does not skip ahead.
  - `drop_err` is tied to 0.

## Test plan

- **Reset:** assert `rst_n = 0` mid-traffic with channels 1 and 3 full -> `dn_valid = 4'b0000` without waiting for a clock edge, `drop_err = 0`. After release, `up_ready = 1` for every `up_sel`.
- **Basic routing and blocking:** `up_sel = 2`, `up_data = 8'hA5`, all `dn_ready = 0` ->
  - next cycle: `dn_valid = 4'b0100`, `dn_data[23:16] = 8'hA5`;
  - a second word to `sel = 2` sees `up_ready = 0`;
  - a word to `sel = 0` is still accepted.
- **Replace on drain:** channel 2 full with `8'hA5`, `dn_ready[2] = 1`, new word `8'h3C` to `sel = 2` -> `up_ready = 1`; next cycle `dn_valid[2] = 1`, `dn_data[23:16] = 8'h3C`, and `8'hA5` is observed consumed exactly once.
- **Out-of-range drop:** `N_OUT = 3`, `up_sel = 3`, `up_data = 8'h77` -> `up_ready = 1`; `drop_err` is high for exactly 1 cycle; `dn_valid` stays `3'b000`.
- **Sustained throughput:** 16 words (`8'h00`..`8'h0F`) to `sel = 1` with `dn_ready[1] = 1` -> all 16 delivered in order on 16 consecutive cycles, and `up_ready` never drops.
- **Round robin** (`STREAM_DEMUX_ROUND_ROBIN_EN`): words `8'h10`..`8'h14` with random `up_sel`, all `dn_ready = 1` -> they land on channels 0, 1, 2, 3, 0. Then hold `dn_ready[1] = 0` with channel 1 full -> the stall holds `rr_ptr = 1`, and channel 2 receives nothing until channel 1 drains.

Source files
------------

// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-N valid/ready stream demultiplexer.
// One upstream stream is steered to one of N_OUT downstream channels. Each
// channel has a one-entry holding register, so a stalled consumer only blocks
// words addressed to its own channel.
//
// Optional feature macro: STREAM_DEMUX_ROUND_ROBIN_EN
//   undefined : target channel = up_sel; out-of-range selects are dropped
//               and flagged on drop_err.
//   defined   : up_sel is ignored; target is an internal round-robin pointer
//               that advances on each accepted word; drop_err is always 0.
//
// Ports
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   up_valid  : upstream word present
//   up_sel    : destination channel index (SEL_W bits)
//   up_data   : upstream payload (WIDTH bits)
//   up_ready  : upstream accept (combinational from dn_ready of the target)
//   dn_valid  : per-channel word present (N_OUT bits)
//   dn_data   : per-channel payload, channel i at [i*WIDTH +: WIDTH]
//   dn_ready  : per-channel consumer ready (N_OUT bits)
//   drop_err  : one-cycle pulse per discarded out-of-range word
module stream_demux #(
    parameter int unsigned N_OUT = 4,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned SEL_W = $clog2(N_OUT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     up_valid,
    input  logic [SEL_W-1:0]         up_sel,
    input  logic [WIDTH-1:0]         up_data,
    output logic                     up_ready,
    output logic [N_OUT-1:0]         dn_valid,
    output logic [N_OUT*WIDTH-1:0]   dn_data,
    input  logic [N_OUT-1:0]         dn_ready,
    output logic                     drop_err
);

    logic [N_OUT-1:0]             valid_q, valid_d;
    logic [N_OUT-1:0][WIDTH-1:0]  data_q, data_d;
    logic                         drop_q, drop_d;

    logic [SEL_W-1:0]             tgt;
    logic                         in_range;
    logic [N_OUT-1:0]             tgt_oh;
    logic [N_OUT-1:0]             acc;

`ifdef STREAM_DEMUX_ROUND_ROBIN_EN
    logic [SEL_W-1:0]             rr_ptr_q, rr_ptr_d;
    logic                         unused_sel;

    // Pointer always names a real channel; up_sel plays no part.
    assign unused_sel = ^up_sel;
    assign tgt        = rr_ptr_q;
    assign in_range   = 1'b1;
`else
    assign tgt        = up_sel;
    assign in_range   = (32'(up_sel) < N_OUT);
`endif

    // One-hot target decode; all-zero when the select is out of range.
    always_comb begin
        tgt_oh = '0;
        for (int i = 0; i < N_OUT; i++) begin
            tgt_oh[i] = in_range && (tgt == SEL_W'(i));
        end
    end

    // Target slot is free if empty or being drained this cycle; drops always accept.
    assign up_ready = !in_range || (|(tgt_oh & (~valid_q | dn_ready)));
    assign acc      = {N_OUT{up_valid && up_ready}} & tgt_oh;

    // Next-state: drain clears, accept sets (accept wins, giving replace-on-drain).
    always_comb begin
        valid_d = (valid_q & ~dn_ready) | acc;
        data_d  = data_q;
        for (int i = 0; i < N_OUT; i++) begin
            if (acc[i]) begin
                data_d[i] = up_data;
            end
        end
`ifdef STREAM_DEMUX_ROUND_ROBIN_EN
        drop_d   = 1'b0;
        rr_ptr_d = rr_ptr_q;
        if (up_valid && up_ready) begin
            rr_ptr_d = (rr_ptr_q == SEL_W'(N_OUT - 1)) ? '0 : rr_ptr_q + SEL_W'(1);
        end
`else
        drop_d  = up_valid && !in_range;
`endif
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            data_q   <= '0;
            drop_q   <= 1'b0;
`ifdef STREAM_DEMUX_ROUND_ROBIN_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            drop_q   <= drop_d;
`ifdef STREAM_DEMUX_ROUND_ROBIN_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    assign dn_valid = valid_q;
    assign dn_data  = data_q;
    assign drop_err = drop_q;

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: table-driven vectors on a 4-channel
// instance plus hand-written sequences for reset, throughput and drops
// (the latter on a 3-channel instance).
module tb_stream_demux;

    logic        clk;
    logic        rst_n;

    // 4-channel instance
    logic        up_valid;
    logic [1:0]  up_sel;
    logic [7:0]  up_data;
    logic        up_ready;
    logic [3:0]  dn_valid;
    logic [31:0] dn_data;
    logic [3:0]  dn_ready;
    logic        drop_err;

    // 3-channel instance
    logic        up_valid3;
    logic [1:0]  up_sel3;
    logic [7:0]  up_data3;
    logic        up_ready3;
    logic [2:0]  dn_valid3;
    logic [23:0] dn_data3;
    logic [2:0]  dn_ready3;
    logic        drop_err3;

    int n_checks = 0;
    int n_fail   = 0;

    stream_demux #(.N_OUT(4), .WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .up_valid(up_valid), .up_sel(up_sel), .up_data(up_data), .up_ready(up_ready),
        .dn_valid(dn_valid), .dn_data(dn_data), .dn_ready(dn_ready), .drop_err(drop_err)
    );

    stream_demux #(.N_OUT(3), .WIDTH(8)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .up_valid(up_valid3), .up_sel(up_sel3), .up_data(up_data3), .up_ready(up_ready3),
        .dn_valid(dn_valid3), .dn_data(dn_data3), .dn_ready(dn_ready3), .drop_err(drop_err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [1:0]  sel;
        logic [7:0]  data;
        logic [3:0]  ready;
        logic        exp_rdy;
        logic [3:0]  exp_v;
        logic [31:0] exp_d;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [1:0] s, input logic [7:0] d,
                                input logic [3:0] r, input logic er,
                                input logic [3:0] ev, input logic [31:0] ed);
        vec_t t;
        t.valid = v; t.sel = s; t.data = d; t.ready = r;
        t.exp_rdy = er; t.exp_v = ev; t.exp_d = ed;
        return t;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Drive one vector at the falling edge, check up_ready, then check state after the rising edge.
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        up_valid = v.valid;
`ifdef STREAM_DEMUX_ROUND_ROBIN_EN
        up_sel   = 2'($urandom_range(0, 3));
`else
        up_sel   = v.sel;
`endif
        up_data  = v.data;
        dn_ready = v.ready;
        #1;
        check("up_ready", idx, 32'(up_ready), 32'(v.exp_rdy));
        @(posedge clk);
        #1;
        check("dn_valid", idx, 32'(dn_valid), 32'(v.exp_v));
        check("dn_data",  idx, dn_data, v.exp_d);
        check("drop_err", idx, 32'(drop_err), 32'd0);
    endtask

    vec_t tbl[$];

    initial begin
        rst_n     = 1'b0;
        up_valid  = 1'b0; up_sel  = '0; up_data  = '0; dn_ready  = '0;
        up_valid3 = 1'b0; up_sel3 = '0; up_data3 = '0; dn_ready3 = '0;

        // Reset state
        #12;
        check("rst_dn_valid", 0, 32'(dn_valid), 32'd0);
        check("rst_dn_data",  0, dn_data, 32'd0);
        check("rst_drop_err", 0, 32'(drop_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef STREAM_DEMUX_ROUND_ROBIN_EN
        // Round robin lands on 0,1,2,3,0 regardless of up_sel; then a stall on ch1.
        tbl.push_back(mk(1, 0, 8'h10, 4'b1111, 1, 4'b0001, 32'h00000010));
        tbl.push_back(mk(1, 0, 8'h11, 4'b1111, 1, 4'b0010, 32'h00001110));
        tbl.push_back(mk(1, 0, 8'h12, 4'b1111, 1, 4'b0100, 32'h00121110));
        tbl.push_back(mk(1, 0, 8'h13, 4'b1111, 1, 4'b1000, 32'h13121110));
        tbl.push_back(mk(1, 0, 8'h14, 4'b1111, 1, 4'b0001, 32'h13121114));
        tbl.push_back(mk(1, 0, 8'h15, 4'b1101, 1, 4'b0010, 32'h13121514));
        tbl.push_back(mk(1, 0, 8'h16, 4'b1101, 1, 4'b0110, 32'h13161514));
        tbl.push_back(mk(1, 0, 8'h17, 4'b1101, 1, 4'b1010, 32'h17161514));
        tbl.push_back(mk(1, 0, 8'h18, 4'b1101, 1, 4'b0011, 32'h17161518));
        tbl.push_back(mk(1, 0, 8'h19, 4'b1101, 0, 4'b0010, 32'h17161518));
        tbl.push_back(mk(1, 0, 8'h19, 4'b1101, 0, 4'b0010, 32'h17161518));
        tbl.push_back(mk(1, 0, 8'h19, 4'b1101, 0, 4'b0010, 32'h17161518));
        tbl.push_back(mk(1, 0, 8'h19, 4'b1111, 1, 4'b0010, 32'h17161918));
        tbl.push_back(mk(1, 0, 8'h1A, 4'b1111, 1, 4'b0100, 32'h171A1918));
`else
        // Routing, blocking, replace-on-drain, independent drain.
        tbl.push_back(mk(1, 2, 8'hA5, 4'b0000, 1, 4'b0100, 32'h00A50000));
        tbl.push_back(mk(1, 2, 8'h5A, 4'b0000, 0, 4'b0100, 32'h00A50000));
        tbl.push_back(mk(1, 0, 8'h11, 4'b0000, 1, 4'b0101, 32'h00A50011));
        tbl.push_back(mk(1, 2, 8'h3C, 4'b0100, 1, 4'b0101, 32'h003C0011));
        tbl.push_back(mk(1, 3, 8'hC3, 4'b0001, 1, 4'b1100, 32'hC33C0011));
        tbl.push_back(mk(0, 3, 8'hFF, 4'b1111, 1, 4'b0000, 32'hC33C0011));
        tbl.push_back(mk(1, 1, 8'h77, 4'b0000, 1, 4'b0010, 32'hC33C7711));
        tbl.push_back(mk(1, 1, 8'h88, 4'b0000, 0, 4'b0010, 32'hC33C7711));
        tbl.push_back(mk(0, 1, 8'h88, 4'b0000, 0, 4'b0010, 32'hC33C7711));
        tbl.push_back(mk(1, 3, 8'h99, 4'b0000, 1, 4'b1010, 32'h993C7711));
`endif
        foreach (tbl[i]) apply(tbl[i], i);

        // Asynchronous reset mid-cycle with channels holding data.
        @(negedge clk);
        up_valid = 1'b0;
        dn_ready = 4'b0000;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_dn_valid", 0, 32'(dn_valid), 32'd0);
        check("async_rst_dn_data",  0, dn_data, 32'd0);
        check("async_rst_drop_err", 0, 32'(drop_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            up_sel = 2'(s);
            #1;
            check("post_rst_up_ready", s, 32'(up_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        check("post_rst_dn_valid", 0, 32'(dn_valid), 32'd0);

`ifndef STREAM_DEMUX_ROUND_ROBIN_EN
        // Sustained throughput into channel 1.
        dn_ready = 4'b0010;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            up_valid = 1'b1;
            up_sel   = 2'd1;
            up_data  = 8'(k);
            #1;
            check("tput_up_ready", k, 32'(up_ready), 32'd1);
            @(posedge clk);
            #1;
            check("tput_dn_valid1", k, 32'(dn_valid), 32'h2);
            check("tput_dn_data1",  k, 32'(dn_data[15:8]), 32'(k));
        end
        @(negedge clk);
        up_valid = 1'b0;
        @(posedge clk);
        #1;
        check("tput_drained", 0, 32'(dn_valid), 32'd0);

        // Out-of-range drops on the 3-channel instance: two back-to-back, then idle.
        @(negedge clk);
        up_valid3 = 1'b1; up_sel3 = 2'd3; up_data3 = 8'h77; dn_ready3 = 3'b000;
        #1;
        check("drop_up_ready", 0, 32'(up_ready3), 32'd1);
        @(posedge clk);
        #1;
        check("drop_err_1", 0, 32'(drop_err3), 32'd1);
        check("drop_valid_1", 0, 32'(dn_valid3), 32'd0);
        @(negedge clk);
        up_data3 = 8'h78;
        @(posedge clk);
        #1;
        check("drop_err_2", 0, 32'(drop_err3), 32'd1);
        @(negedge clk);
        up_valid3 = 1'b0;
        @(posedge clk);
        #1;
        check("drop_err_low", 0, 32'(drop_err3), 32'd0);
        check("drop_valid_2", 0, 32'(dn_valid3), 32'd0);
        // Single drop pulses for exactly one cycle.
        @(negedge clk);
        up_valid3 = 1'b1; up_sel3 = 2'd3; up_data3 = 8'h55;
        @(posedge clk);
        #1;
        check("drop_single_hi", 0, 32'(drop_err3), 32'd1);
        @(negedge clk);
        up_valid3 = 1'b0;
        @(posedge clk);
        #1;
        check("drop_single_lo", 0, 32'(drop_err3), 32'd0);
        // In-range word on the 3-channel instance.
        @(negedge clk);
        up_valid3 = 1'b1; up_sel3 = 2'd2; up_data3 = 8'h05;
        #1;
        check("n3_up_ready", 0, 32'(up_ready3), 32'd1);
        @(posedge clk);
        #1;
        check("n3_dn_valid", 0, 32'(dn_valid3), 32'h4);
        check("n3_dn_data",  0, 32'(dn_data3), 32'h050000);
        check("n3_drop_err", 0, 32'(drop_err3), 32'd0);
        @(negedge clk);
        up_valid3 = 1'b0;
`endif

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
